double_to_sig16b: RTL and testbench

Converts an IEEE-754 double result from the echo-cancellation datapath back to a 16-bit signed fixed-point sample for the output/DAC side. It is the return path of the 16-bit-to-double front end. It uses the same pulse-enable/ready handshake on clk_operation, has fixed latency, and saturates at the 16-bit limits.

---
 rtl/double_to_sig16b.sv | 94 +++++++++
 tb/tb_double_to_sig16b.sv | 122 ++++++++++++
 2 files changed

// File: rtl/double_to_sig16b.sv
// double_to_sig16b: IEEE-754 double to saturating 16-bit signed fixed point, fixed 4-cycle latency
// Ports: clk_operation (clock), rst (sync, active-low), enable (start on rising edge), double (operand),
//        sig16b (result), ready (held until next start), overflow (saturated), invalid (NaN operand)
// Build option: define D2S_ROUND_NEAREST_EN to round half away from zero; otherwise truncate toward zero
module double_to_sig16b #(
  parameter int FRAC_BITS = 15
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] double,
  output logic [15:0] sig16b,
  output logic        ready,
  output logic        overflow,
  output logic        invalid
);
`ifdef D2S_ROUND_NEAREST_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif
  localparam logic [2:0] IDLE = 3'd0, ALIGN = 3'd1, SHIFT = 3'd2, ROUND = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic enable_d, pend, rise, start;
  logic [63:0] d_r;
  logic signed [11:0] s_c, s_r;
  logic zero_r, nan_r, sat_r, grd_r;
  logic [16:0] mag_r;
  logic [17:0] rnd_r, sh_c;
  logic [5:0] amt_c;
  logic [15:0] res_c;
  logic ovf_c;
  always_comb begin
    rise = enable && !enable_d;
    // a rise seen during DONE is held one cycle so it starts as soon as IDLE is reached
    start = state == IDLE && (rise || pend);
    s_c = 12'(int'(d_r[62:52]) - 1023 + FRAC_BITS);
    // shift leaves the guard bit in bit 0 and the integer magnitude above it
    amt_c = 6'(12'sd51 - s_r);
    sh_c = 18'({1'b1, d_r[51:0]} >> amt_c);
    ovf_c = sat_r || (d_r[63] ? rnd_r > 18'd32768 : rnd_r > 18'd32767);
    res_c = nan_r || zero_r ? 16'h0000 :
            ovf_c ? (d_r[63] ? 16'h8000 : 16'h7FFF) :
            d_r[63] ? 16'(-rnd_r) : rnd_r[15:0];
  end
  always_ff @(posedge clk_operation) begin
    if (!rst) begin
      state <= IDLE;
      enable_d <= 1'b0;
      pend <= 1'b0;
      sig16b <= 16'h0000;
      ready <= 1'b0;
      overflow <= 1'b0;
      invalid <= 1'b0;
    end else begin
      enable_d <= enable;
      pend <= rise && state == DONE;
      if (start) begin
        d_r <= double;
        ready <= 1'b0;
        overflow <= 1'b0;
        invalid <= 1'b0;
        state <= ALIGN;
      end else begin
        case (state)
          ALIGN: begin
            s_r <= s_c;
            nan_r <= &d_r[62:52] && |d_r[51:0];
            zero_r <= d_r[62:52] == 11'd0 || s_c < -12'sd2;
            sat_r <= !(&d_r[62:52] && |d_r[51:0]) && s_c > 12'sd16;
            state <= SHIFT;
          end
          SHIFT: begin
            mag_r <= sh_c[17:1];
            grd_r <= sh_c[0];
            state <= ROUND;
          end
          ROUND: begin
            rnd_r <= {1'b0, mag_r} + 18'(grd_r & RND);
            state <= DONE;
          end
          DONE: begin
            sig16b <= res_c;
            overflow <= !nan_r && !zero_r && ovf_c;
            invalid <= nan_r;
            ready <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_double_to_sig16b.sv
// tb_double_to_sig16b: scoreboard bench for double_to_sig16b with directed operands
module tb_double_to_sig16b;
  logic clk_operation = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [63:0] double = 64'd0;
  logic [15:0] sig16b;
  logic ready, overflow, invalid;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic rdy_q = 1'b0;
  typedef struct {logic [15:0] v; logic o; logic i; int due;} exp_t;
  exp_t sb[$];
  double_to_sig16b #(.FRAC_BITS(15)) dut (
    .clk_operation(clk_operation), .rst(rst), .enable(enable), .double(double),
    .sig16b(sig16b), .ready(ready), .overflow(overflow), .invalid(invalid)
  );
  always #5 clk_operation = ~clk_operation;
  always @(posedge clk_operation) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  always @(negedge clk_operation) begin
    if (ready && !rdy_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", sig16b);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sig16b", 32'(sig16b), 32'(e.v));
        chk("overflow", 32'(overflow), 32'(e.o));
        chk("invalid", 32'(invalid), 32'(e.i));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
    rdy_q = ready;
  end
  task automatic drain();
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk_operation);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=pending%0d required=0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk_operation);
  endtask
  task automatic conv(input logic [63:0] d, input logic [15:0] v, input logic o, input logic i);
    sb.push_back('{v, o, i, cyc + 5});
    enable = 1'b1;
    double = d;
    repeat (2) @(negedge clk_operation);
    enable = 1'b0;
    drain();
  endtask
  initial begin
    repeat (3) @(negedge clk_operation);
    chk("rst_sig16b", 32'(sig16b), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_flags", 32'({overflow, invalid}), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk_operation);
    chk("idle_ready", 32'(ready), 32'h0);
    conv(64'h3FE0000000000000, 16'h4000, 1'b0, 1'b0);
    conv(64'hBFD0000000000000, 16'hE000, 1'b0, 1'b0);
    conv(64'h3FF0000000000000, 16'h7FFF, 1'b1, 1'b0);
    conv(64'hBFF0000000000000, 16'h8000, 1'b0, 1'b0);
    conv(64'hC000000000000000, 16'h8000, 1'b1, 1'b0);
    conv(64'h7FF0000000000000, 16'h7FFF, 1'b1, 1'b0);
    conv(64'hFFF0000000000000, 16'h8000, 1'b1, 1'b0);
    conv(64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1);
    conv(64'h8000000000000000, 16'h0000, 1'b0, 1'b0);
    conv(64'h0000000000000001, 16'h0000, 1'b0, 1'b0);
    conv(64'h3F00000000000000, 16'h0001, 1'b0, 1'b0);
`ifdef D2S_ROUND_NEAREST_EN
    conv(64'h3EF0000000000000, 16'h0001, 1'b0, 1'b0);
    conv(64'h3EF8000000000000, 16'h0001, 1'b0, 1'b0);
    conv(64'h3F08000000000000, 16'h0002, 1'b0, 1'b0);
    conv(64'hBF08000000000000, 16'hFFFE, 1'b0, 1'b0);
    conv(64'h3FEFFFFFFFFFFFFF, 16'h7FFF, 1'b1, 1'b0);
`else
    conv(64'h3EF0000000000000, 16'h0000, 1'b0, 1'b0);
    conv(64'h3EF8000000000000, 16'h0000, 1'b0, 1'b0);
    conv(64'h3F08000000000000, 16'h0001, 1'b0, 1'b0);
    conv(64'hBF08000000000000, 16'hFFFF, 1'b0, 1'b0);
    conv(64'h3FEFFFFFFFFFFFFF, 16'h7FFF, 1'b0, 1'b0);
`endif
    sb.push_back('{16'h4000, 1'b0, 1'b0, cyc + 5});
    enable = 1'b1;
    double = 64'h3FE0000000000000;
    @(negedge clk_operation);
    enable = 1'b0;
    @(negedge clk_operation);
    enable = 1'b1;
    double = 64'hBFF0000000000000;
    repeat (2) @(negedge clk_operation);
    enable = 1'b0;
    drain();
    repeat (6) @(negedge clk_operation);
    enable = 1'b1;
    double = 64'h3FD0000000000000;
    repeat (2) @(negedge clk_operation);
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk_operation);
    rst = 1'b1;
    chk("abort_ready", 32'(ready), 32'h0);
    chk("abort_sig16b", 32'(sig16b), 32'h0);
    repeat (8) @(negedge clk_operation);
    chk("abort_no_result", 32'(ready), 32'h0);
    conv(64'hBFE0000000000000, 16'hC000, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
